// File: rtl/crg_rst_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package crg_rst_seq_pkg;

  typedef enum logic [2:0] {
    StRst,
    StWait,
    StLoad,
    StHold,
    StReq,
    StRun
  } chan_state_e;

  localparam int unsigned DEF_CW   = 12;
  localparam int unsigned DEF_HOLD = 1295;

endpackage

// File: rtl/rst_chan_ctrl.sv
// One reset channel: state machine, hold counter and registered active-low reset output.
module rst_chan_ctrl
  import crg_rst_seq_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          grst_s_i,
  input  logic          req_s_i,
  input  logic          lower_run_i,
  input  logic [CW-1:0] hold_cycles_i,
  output logic          run_o,
  output logic          arst_no_o
);

  chan_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          arst_no_q;
  logic          do_load;
  logic          short_hold;

  // The load happens on the transition edge itself, so StLoad never occupies a cycle.
  always_comb begin
    do_load = 1'b0;
    case (state_q)
      StRst:          do_load = grst_s_i & lower_run_i;
      StWait, StLoad: do_load = lower_run_i;
      StReq:          do_load = 1'b1;
      default:        do_load = 1'b0;
    endcase
  end

  // Hold of 0 behaves as 1: release on the loading edge.
  assign short_hold = (hold_cycles_i < CW'(2));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRst;
      cnt_q     <= '0;
      arst_no_q <= 1'b0;
    end else if (req_s_i && (state_q != StRst || grst_s_i)) begin
      state_q   <= StReq;
      arst_no_q <= 1'b0;
    end else if (do_load) begin
      if (short_hold) begin
        state_q   <= StRun;
        arst_no_q <= 1'b1;
      end else begin
        state_q <= StHold;
        cnt_q   <= hold_cycles_i - CW'(1);
      end
    end else begin
      case (state_q)
        StRst: begin
          if (grst_s_i) state_q <= StWait;
        end
        StHold: begin
          if (cnt_q < CW'(2)) begin
            state_q   <= StRun;
            arst_no_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign run_o     = (state_q == StRun);
  assign arst_no_o = arst_no_q;

endmodule

// File: rtl/crg_rst_seq.sv
// Staged reset sequencer: synchronisers, stage gating and busy flag around N channel controllers.
module crg_rst_seq
  import crg_rst_seq_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = DEF_CW,
  parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            ref_clk_i,
  input  logic            glob_arst_ni,
  input  logic [N-1:0]    arst_req_i,
  input  logic [N*CW-1:0] hold_cycles_i,
  input  logic [N*SW-1:0] stage_i,
  output logic [N-1:0]    arst_no,
  output logic            busy_o
);

  logic         grst_q1, grst_s;
  logic [N-1:0] req_q1, req_s;
  logic [N-1:0] run;
  logic [N-1:0] lower_run;
  logic         busy_q;

  always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
    if (!glob_arst_ni) begin
      grst_q1 <= 1'b0;
      grst_s  <= 1'b0;
      req_q1  <= '0;
      req_s   <= '0;
    end else begin
      grst_q1 <= 1'b1;
      grst_s  <= grst_q1;
      req_q1  <= arst_req_i;
      req_s   <= req_q1;
    end
  end

  // A channel may load once every channel on a strictly lower stage is running.
  always_comb begin
    lower_run = '1;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if ((stage_i[j*SW +: SW] < stage_i[i*SW +: SW]) && !run[j]) begin
          lower_run[i] = 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : gen_chan
    rst_chan_ctrl #(
      .CW(CW)
    ) u_chan (
      .clk_i        (ref_clk_i),
      .rst_ni       (glob_arst_ni),
      .grst_s_i     (grst_s),
      .req_s_i      (req_s[g]),
      .lower_run_i  (lower_run[g]),
      .hold_cycles_i(hold_cycles_i[g*CW +: CW]),
      .run_o        (run[g]),
      .arst_no_o    (arst_no[g])
    );
  end

  always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
    if (!glob_arst_ni) begin
      busy_q <= 1'b1;
    end else begin
      busy_q <= ~&run;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: doc/crg_rst_seq.md
# crg_rst_seq

Parametrised, staged reset sequencer for the clock-and-reset generator. It generalises the fixed-delay per-output reset path to N channels. Each channel has its own programmable hold count and release stage, and supports local re-reset requests. After a global reset, channels are released in ascending stage order. Runs on the reference clock and drives the per-output `arst_no` lines consumed by the clock-output domains.

## Interface
- `N`, 8: number of reset channels.
- `CW`, 12: hold-counter width.
- `SW`, `$clog2(N)`: stage-index width.
- `ref_clk_i` input, 1 bit: reference clock. This is the only clock.
- `glob_arst_ni` input, 1 bit: global reset, asynchronous, active-low.
- `arst_req_i[N]` input, 1 bit each: per-channel reset request, active-high, asynchronous to `ref_clk_i`.
- `hold_cycles_i[N]` input, `CW` bits each: release delay in `ref_clk_i` cycles.
- `stage_i[N]` input, `SW` bits each: release stage; lower stages release first.
- `arst_no[N]` output, 1 bit each: channel reset, active-low.
- `busy_o` output, 1 bit: high while any channel is not in RUN.

## Operation
- Reset values while `glob_arst_ni` = 0:
  - every `arst_no[i]` = 0, asserted asynchronously;
  - `busy_o` = 1;
  - all channels in state RST.
- Global deassertion passes through a 2-flop synchroniser (`grst_s`). Each `arst_req_i[i]` passes through its own 2-flop synchroniser (`req_s[i]`).
- Per-channel FSM:
  - RST, while `grst_s` is asserted → WAIT.
  - WAIT → LOAD when all channels with a lower `stage_i` are in RUN. Empty stages are skipped implicitly.
  - WAIT → HOLD directly if entered via a local request (no stage gating).
  - LOAD: `cnt` ← `hold_cycles_i[i]`, with 0 treated as 1 → HOLD.
  - HOLD: `cnt` decrements; at `cnt` = 1 → RUN.
  - RUN: `arst_no[i]` = 1.
  - Any state with `req_s[i]` = 1 → REQ, with `arst_no[i]` = 0.
  - REQ with `req_s[i]` = 0 → HOLD, loading `cnt` in the same edge. This bypasses stage gating.
- `arst_no[i]` is 0 in every state except RUN. It is registered, so deassertion is always synchronous to a rising edge of `ref_clk_i`.
- `hold_cycles_i` and `stage_i` are sampled only at load. Changes during HOLD are ignored.
- Request asserted during HOLD: the count is abandoned and restarts in full when the request falls.
- A lower-stage channel re-entering REQ after the higher stages are in RUN has no effect on those higher stages.
- A lower-stage channel held in REQ during the global sequence blocks all higher stages until it reaches RUN.
- `glob_arst_ni` falling mid-sequence returns every channel to RST immediately, with no clock required.
- `busy_o` = OR over channels of (state ≠ RUN), registered.

## Timing
- Global release, stage-0 channel with hold H and no request: `arst_no` rises on rising edge 2+H after `glob_arst_ni` rises, counted from the first `ref_clk_i` edge. H = 1295 → edge 1297.
- Stage k>0 channel: rises H_k edges after the last lower-stage channel reaches RUN.
- Local request: `arst_no[i]` falls on the 3rd rising edge after `arst_req_i[i]` rises, provided `arst_req_i[i]` is stable for ≥1 cycle.
- Local release: `arst_no[i]` rises on edge 2+H after `arst_req_i[i]` falls.
- Requests shorter than 2 `ref_clk_i` periods may be missed. Filtering of such pulses is not guaranteed.
- `busy_o` falls one edge after the last `arst_no` rises.

## Structure
- Package `crg_rst_seq_pkg`:
  - `chan_state_e` enum: RST, WAIT, LOAD, HOLD, REQ, RUN;
  - default `CW`;
  - `DEF_HOLD` = 1295.
- Sub-module `rst_chan_ctrl`: one channel's FSM, counter and output flop, instantiated N times in a generate loop. The top level holds:
  - the synchronisers;
  - the stage-gating comparison (lower-stage-all-RUN vector);
  - `busy_o`.

## Test plan
- N=8, all `stage_i`=0, `hold_cycles_i`=1295, release `glob_arst_ni` → all `arst_no` rise on edge 1297; `busy_o` falls on edge 1298.
- Stages 0/1/2 with holds 10/20/5 → releases on edges 12, 32, 37 after global release.
- `hold_cycles_i[3]`=0 → channel 3 releases on edge 3 (treated as H=1).
- `arst_req_i[5]` pulsed for 4 cycles while all channels are in RUN, H=50 → `arst_no[5]` falls 3 edges after assertion and rises 52 edges after deassertion; the other channels stay high.
- `arst_req_i[0]` held during the global sequence, with channel 0 at stage 0 and channel 1 at stage 1 → channel 1 stays low until channel 0 reaches RUN.
- `glob_arst_ni` dropped mid-HOLD → all `arst_no` = 0 and `busy_o` = 1 immediately (asynchronous); the sequence restarts from scratch on release.
